nibble_serial_add_ctrl: RTL and testbench

NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

---
 rtl/nsa_pkg.sv | 12 +
 rtl/adder4.sv | 26 ++
 rtl/nibble_serial_add_ctrl.sv | 114 +++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package nsa_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder4.sv
// Combinational 4-bit ripple-carry adder; the controller time-shares one instance across all nibbles.
module adder4
    import nsa_pkg::*;
(
    input  logic [NIBBLE_W-1:0] A,
    input  logic [NIBBLE_W-1:0] B,
    input  logic                CI,
    output logic [NIBBLE_W-1:0] SUM,
    output logic                CO
);

    logic carry;

    // NOTE: blocking assignments here let the carry variable ripple bit by bit within one evaluation;
    // every output gets a default first so no latch can be inferred.
    always_comb begin
        SUM   = '0;
        carry = CI;
        for (int i = 0; i < NIBBLE_W; i++) begin
            SUM[i] = A[i] ^ B[i] ^ carry;
            carry  = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
        end
        CO = carry;
    end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial W-bit adder: one 4-bit adder processes one nibble per RUN cycle, LSB nibble first.
// Optional macro NSA_SUB_EN adds a 'sub' input that turns the operation into op_a - op_b.
module nibble_serial_add_ctrl
    import nsa_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [NIBBLE_W*NIBBLES-1:0] op_a,
    input  logic [NIBBLE_W*NIBBLES-1:0] op_b,
    input  logic                    cin,
`ifdef NSA_SUB_EN
    input  logic                    sub,
`endif
    output logic                    busy,
    output logic                    done,
    output logic [NIBBLE_W*NIBBLES-1:0] sum,
    output logic                    cout
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic               carry;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;

    logic [W-1:0]        b_in;
    logic                ci_in;
    logic [NIBBLE_W-1:0] add_a;
    logic [NIBBLE_W-1:0] add_b;
    logic [NIBBLE_W-1:0] add_sum;
    logic                add_co;
    logic                last;

    // Subtraction is a + ~b + 1, so the mode is folded into the captured operand and carry.
`ifdef NSA_SUB_EN
    assign b_in  = sub ? ~op_b : op_b;
    assign ci_in = sub | cin;
`else
    assign b_in  = op_b;
    assign ci_in = cin;
`endif

    always_comb begin
        add_a = a_q[idx*NIBBLE_W +: NIBBLE_W];
        add_b = b_q[idx*NIBBLE_W +: NIBBLE_W];
        last  = (idx == IDX_W'(NIBBLES - 1));
    end

    adder4 u_adder4 (
        .A   (add_a),
        .B   (add_b),
        .CI  (carry),
        .SUM (add_sum),
        .CO  (add_co)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= op_a;
                        b_q   <= b_in;
                        carry <= ci_in;
                        idx   <= '0;
                        sum   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum[idx*NIBBLE_W +: NIBBLE_W] <= add_sum;
                    carry <= add_co;
                    if (last) begin
                        cout  <= add_co;
                        idx   <= '0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench: an arithmetic reference model plus directed vectors with literal expectations.
module tb_nibble_serial_add_ctrl;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;
`ifdef NSA_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         sub_i;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op_a  (op_a),
        .op_b  (op_b),
        .cin   (cin),
`ifdef NSA_SUB_EN
        .sub   (sub_i),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: m_cnt is -1 when idle, otherwise edges elapsed since the accepting edge.
    int           m_cnt = -1;
    logic [W:0]   m_pend = '0;
    logic [W-1:0] m_sum = '0;
    logic         m_cout = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt  = -1;
            m_sum  = '0;
            m_cout = 1'b0;
        end else if (m_cnt < 0) begin
            if (start) begin
                m_pend = {1'b0, op_a}
                       + {1'b0, (SUB_EN && sub_i) ? ~op_b : op_b}
                       + (W+1)'((SUB_EN && sub_i) ? 1'b1 : cin);
                m_sum  = '0;
                m_cnt  = 0;
            end
        end else if (m_cnt == NIBBLES) begin
            m_cnt = -1;
        end else begin
            m_cnt++;
            if (m_cnt == NIBBLES) {m_cout, m_sum} = m_pend;
        end
    end

    always @(negedge clk) begin
        check("busy", 64'(busy), 64'(m_cnt >= 0));
        check("done", 64'(done), 64'(m_cnt == NIBBLES));
        if (m_cnt < 0 || m_cnt == NIBBLES) begin
            check("sum",  64'(sum),  64'(m_sum));
            check("cout", 64'(cout), 64'(m_cout));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one request and returns the number of edges until done is seen (accepting edge = 1).
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          input logic s, output int lat);
        op_a  = a;
        op_b  = b;
        cin   = ci;
        sub_i = s;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 30) begin
            tick();
            lat++;
        end
        if (!done) check("done_timeout", 64'(lat), 64'(NIBBLES + 1));
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
    } vec_t;

    vec_t vecs[4] = '{
        '{16'hFFFF, 16'hFFFF, 1'b1},
        '{16'h8000, 16'h8000, 1'b0},
        '{16'hABCD, 16'h1234, 1'b0},
        '{16'h0F0F, 16'hF0F0, 1'b1}
    };

    initial begin
        int           lat;
        int           seen;
        logic [W:0]   exp_full;

        rst   = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        cin   = 1'b0;
        sub_i = 1'b0;
        tick();
        tick();
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_sum",  64'(sum),  64'(0));
        check("rst_cout", 64'(cout), 64'(0));

        // Start in the very first edge after reset release.
        rst = 1'b0;
        run_op(16'h1234, 16'h1111, 1'b0, 1'b0, lat);
        check("basic_lat",  64'(lat),  64'(5));
        check("basic_sum",  64'(sum),  64'(16'h2345));
        check("basic_cout", 64'(cout), 64'(0));
        tick();
        check("basic_busy_fall", 64'(busy), 64'(0));
        check("basic_done_fall", 64'(done), 64'(0));
        check("basic_sum_hold",  64'(sum),  64'(16'h2345));

        run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, lat);
        check("chain_sum",  64'(sum),  64'(16'h0000));
        check("chain_cout", 64'(cout), 64'(1));
        tick();

        foreach (vecs[i]) begin
            exp_full = {1'b0, vecs[i].a} + {1'b0, vecs[i].b} + (W+1)'(vecs[i].ci);
            run_op(vecs[i].a, vecs[i].b, vecs[i].ci, 1'b0, lat);
            check("tbl_lat",  64'(lat),  64'(5));
            check("tbl_sum",  64'(sum),  64'(exp_full[W-1:0]));
            check("tbl_cout", 64'(cout), 64'(exp_full[W]));
            tick();
        end
        check("wrap_8000_sum", 64'(sum), 64'(16'h0000));

        // Requests in RUN and DONE must be ignored.
        op_a  = 16'h0001;
        op_b  = 16'h0001;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        op_a  = 16'h0F0F;
        op_b  = 16'h0F0F;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat   = 0;
        while (!done && lat < 30) begin
            tick();
            lat++;
        end
        check("busy_req_done", 64'(done), 64'(1));
        check("busy_req_sum",  64'(sum),  64'(16'h0002));
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_req_idle", 64'(busy), 64'(0));
        check("busy_req_hold", 64'(sum),  64'(16'h0002));
        tick();
        check("busy_req_no_restart", 64'(busy), 64'(0));

        // Reset while idx = 2.
        op_a  = 16'h1234;
        op_b  = 16'h0001;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_sum",  64'(sum),  64'(0));
        check("midrst_done", 64'(done), 64'(0));
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (done) seen++;
        end
        check("midrst_no_done", 64'(seen), 64'(0));
        rst = 1'b0;
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, lat);
        check("postrst_lat", 64'(lat), 64'(5));
        check("postrst_sum", 64'(sum), 64'(16'h0100));
        tick();

`ifdef NSA_SUB_EN
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, lat);
        check("sub_borrow_sum",  64'(sum),  64'(16'hFFFE));
        check("sub_borrow_cout", 64'(cout), 64'(0));
        tick();
        run_op(16'h0007, 16'h0005, 1'b0, 1'b1, lat);
        check("sub_sum",  64'(sum),  64'(16'h0002));
        check("sub_cout", 64'(cout), 64'(1));
        tick();
`endif

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
